// File: rtl/vdp_vram_arbiter.sv
// VRAM port arbiter: one-deep posted CPU buffer vs. display fetcher,
// render priority during active display with a bounded CPU wait.
module vdp_vram_arbiter #(
    parameter int ADDR_W   = 14,
    parameter int DATA_W   = 8,
    parameter int MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              display_active,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_busy,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_rvalid,
    input  logic              ren_req,
    input  logic [ADDR_W-1:0] ren_addr,
    output logic              ren_gnt,
    output logic [DATA_W-1:0] ren_rdata,
    output logic              ren_rvalid,
    output logic [ADDR_W-1:0] vram_addr,
    output logic              vram_re,
    output logic              vram_we,
    output logic [DATA_W-1:0] vram_wdata,
    input  logic [DATA_W-1:0] vram_rdata
);

    localparam int WCNT_W = $clog2(MAX_WAIT + 1);
    localparam logic [WCNT_W-1:0] WAIT_LIMIT = WCNT_W'(MAX_WAIT);

    typedef enum logic {EMPTY, PEND} state_t;

    state_t            state_q, state_d;
    logic              p_we_q, p_we_d;
    logic [ADDR_W-1:0] p_addr_q, p_addr_d;
    logic [DATA_W-1:0] p_wdata_q, p_wdata_d;
    logic [WCNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic [ADDR_W-1:0] vram_addr_q, vram_addr_d;
    logic              vram_re_q, vram_re_d;
    logic              vram_we_q, vram_we_d;
    logic [DATA_W-1:0] vram_wdata_q, vram_wdata_d;
    logic [1:0]        tag1_q, tag1_d;
    logic [1:0]        tag2_q, tag2_d;

    logic pend;
    logic cpu_win;
    logic ren_win;

    // Arbitration: CPU only yields to render while display is active and
    // it has not yet used up its wait budget.
    always_comb begin
        pend    = (state_q == PEND);
        cpu_win = pend && (!ren_req || !display_active || (wait_cnt_q >= WAIT_LIMIT));
        ren_win = ren_req && !cpu_win;
    end

    always_comb begin
        state_d      = state_q;
        p_we_d       = p_we_q;
        p_addr_d     = p_addr_q;
        p_wdata_d    = p_wdata_q;
        wait_cnt_d   = wait_cnt_q;
        vram_addr_d  = vram_addr_q;
        vram_re_d    = 1'b0;
        vram_we_d    = 1'b0;
        vram_wdata_d = vram_wdata_q;
        tag1_d       = 2'b00;
        tag2_d       = tag1_q;

        // No bypass: a request arriving while PEND is dropped, even on the issue edge.
        case (state_q)
            EMPTY: begin
                if (cpu_req) begin
                    state_d   = PEND;
                    p_we_d    = cpu_we;
                    p_addr_d  = cpu_addr;
                    p_wdata_d = cpu_wdata;
                end
            end
            PEND: begin
                if (cpu_win) begin
                    state_d = EMPTY;
                end
            end
            default: state_d = EMPTY;
        endcase

        if (!pend || cpu_win) begin
            wait_cnt_d = '0;
        end else if (wait_cnt_q < WAIT_LIMIT) begin
            wait_cnt_d = wait_cnt_q + WCNT_W'(1);
        end

        if (cpu_win) begin
            vram_addr_d = p_addr_q;
            vram_we_d   = p_we_q;
            vram_re_d   = !p_we_q;
            tag1_d      = {!p_we_q, 1'b0};
            if (p_we_q) begin
                vram_wdata_d = p_wdata_q;
            end
        end else if (ren_win) begin
            vram_addr_d = ren_addr;
            vram_re_d   = 1'b1;
            tag1_d      = 2'b01;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= EMPTY;
            p_we_q       <= 1'b0;
            p_addr_q     <= '0;
            p_wdata_q    <= '0;
            wait_cnt_q   <= '0;
            vram_addr_q  <= '0;
            vram_re_q    <= 1'b0;
            vram_we_q    <= 1'b0;
            vram_wdata_q <= '0;
            tag1_q       <= 2'b00;
            tag2_q       <= 2'b00;
        end else begin
            state_q      <= state_d;
            p_we_q       <= p_we_d;
            p_addr_q     <= p_addr_d;
            p_wdata_q    <= p_wdata_d;
            wait_cnt_q   <= wait_cnt_d;
            vram_addr_q  <= vram_addr_d;
            vram_re_q    <= vram_re_d;
            vram_we_q    <= vram_we_d;
            vram_wdata_q <= vram_wdata_d;
            tag1_q       <= tag1_d;
            tag2_q       <= tag2_d;
        end
    end

    // Read data returns one cycle after vram_re; tag2 lines up with it.
    assign cpu_busy   = pend;
    assign ren_gnt    = ren_win;
    assign vram_addr  = vram_addr_q;
    assign vram_re    = vram_re_q;
    assign vram_we    = vram_we_q;
    assign vram_wdata = vram_wdata_q;
    assign cpu_rvalid = tag2_q[1];
    assign ren_rvalid = tag2_q[0];
    assign cpu_rdata  = vram_rdata;
    assign ren_rdata  = vram_rdata;

endmodule

// File: tb/tb_vdp_vram_arbiter.sv
// Bench for vdp_vram_arbiter: VRAM model, read-return scoreboard and
// cycle-accurate directed checks of grant/busy/issue timing.
module tb_vdp_vram_arbiter;

    localparam int ADDR_W   = 14;
    localparam int DATA_W   = 8;
    localparam int MAX_WAIT = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic              display_active;
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_busy;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_rvalid;
    logic              ren_req;
    logic [ADDR_W-1:0] ren_addr;
    logic              ren_gnt;
    logic [DATA_W-1:0] ren_rdata;
    logic              ren_rvalid;
    logic [ADDR_W-1:0] vram_addr;
    logic              vram_re;
    logic              vram_we;
    logic [DATA_W-1:0] vram_wdata;
    logic [DATA_W-1:0] vram_rdata;

    vdp_vram_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_WAIT(MAX_WAIT)
    ) dut (
        .clk(clk), .reset(reset), .display_active(display_active),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_busy(cpu_busy), .cpu_rdata(cpu_rdata),
        .cpu_rvalid(cpu_rvalid), .ren_req(ren_req), .ren_addr(ren_addr),
        .ren_gnt(ren_gnt), .ren_rdata(ren_rdata), .ren_rvalid(ren_rvalid),
        .vram_addr(vram_addr), .vram_re(vram_re), .vram_we(vram_we),
        .vram_wdata(vram_wdata), .vram_rdata(vram_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic              is_cpu;
        logic [DATA_W-1:0] data;
    } rd_exp_t;

    rd_exp_t     exp_q[$];
    logic [7:0]  mem [0:(1<<ADDR_W)-1];
    int          n_checks = 0;
    int          n_pass   = 0;
    int          wr_cnt   = 0;
    logic [ADDR_W-1:0] last_wr_addr = '0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    endtask

    // Synchronous VRAM model with one-cycle read latency.
    always @(posedge clk) begin
        if (vram_we) begin
            mem[vram_addr] <= vram_wdata;
            wr_cnt         <= wr_cnt + 1;
            last_wr_addr   <= vram_addr;
        end
        if (vram_re) vram_rdata <= mem[vram_addr];
    end

    // Return monitor: every rvalid must match the oldest expected read.
    always @(negedge clk) begin
        check_eq("re_we_excl", {31'd0, vram_re & vram_we}, 32'd0);
        if (cpu_rvalid || ren_rvalid) begin
            if (exp_q.size() == 0) begin
                check_eq("rvalid_unexpected", {30'd0, cpu_rvalid, ren_rvalid}, 32'd0);
            end else begin
                rd_exp_t e;
                e = exp_q.pop_front();
                check_eq("rv_owner", {30'd0, cpu_rvalid, ren_rvalid}, e.is_cpu ? 32'd2 : 32'd1);
                check_eq("rv_data", e.is_cpu ? {24'd0, cpu_rdata} : {24'd0, ren_rdata}, {24'd0, e.data});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_rd(input logic is_cpu, input logic [DATA_W-1:0] d);
        rd_exp_t e;
        e.is_cpu = is_cpu;
        e.data   = d;
        exp_q.push_back(e);
    endtask

    // Render held high during display while one CPU access pends.
    // CPU pends from k=1, loses k=1..4, wins at k=5.
    task automatic contend(input logic we, input logic [ADDR_W-1:0] a,
                           input logic [DATA_W-1:0] wd, input logic exp_rd,
                           input logic drop_second);
        display_active = 1'b1;
        for (int k = 0; k < 8; k++) begin
            tick();
            ren_req   = 1'b1;
            ren_addr  = ADDR_W'(14'h0200 + k);
            cpu_req   = (k == 0) || (drop_second && k == 1);
            cpu_we    = (k == 0) ? we : 1'b1;
            cpu_addr  = (k == 0) ? a : 14'h0010;
            cpu_wdata = (k == 0) ? wd : 8'h99;
            #1;
            check_eq($sformatf("ren_gnt_k%0d", k), {31'd0, ren_gnt}, (k != 5) ? 32'd1 : 32'd0);
            check_eq($sformatf("busy_k%0d", k), {31'd0, cpu_busy}, (k >= 1 && k <= 5) ? 32'd1 : 32'd0);
            if (k != 5) push_rd(1'b0, mem[ren_addr]);
            else if (exp_rd) push_rd(1'b1, 8'h5A);
        end
        tick();
        ren_req = 1'b0;
        cpu_req = 1'b0;
        repeat (3) tick();
    endtask

    int wr_before;

    initial begin
        for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = 8'(i ^ (i >> 6));
        mem[14'h0123] = 8'h5A;
        reset = 1'b1; display_active = 1'b0;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        ren_req = 1'b0; ren_addr = '0;
        repeat (2) tick();
        check_eq("rst_busy", {31'd0, cpu_busy}, 0);
        check_eq("rst_en", {30'd0, vram_re, vram_we}, 0);
        check_eq("rst_addr", {18'd0, vram_addr}, 0);
        check_eq("rst_wdata", {24'd0, vram_wdata}, 0);
        check_eq("rst_rvalid", {30'd0, cpu_rvalid, ren_rvalid}, 0);
        check_eq("rst_gnt", {31'd0, ren_gnt}, 0);
        reset = 1'b0;
        tick();

        // CPU write on idle bus
        tick();
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 14'h3FFF; cpu_wdata = 8'hA5;
        #1 check_eq("wr_busy_N", {31'd0, cpu_busy}, 0);
        tick(); cpu_req = 1'b0;
        check_eq("wr_busy_N1", {31'd0, cpu_busy}, 1);
        check_eq("wr_we_N1", {31'd0, vram_we}, 0);
        tick();
        check_eq("wr_busy_N2", {31'd0, cpu_busy}, 0);
        check_eq("wr_we_N2", {31'd0, vram_we}, 1);
        check_eq("wr_re_N2", {31'd0, vram_re}, 0);
        check_eq("wr_addr_N2", {18'd0, vram_addr}, 32'h3FFF);
        check_eq("wr_data_N2", {24'd0, vram_wdata}, 32'hA5);
        tick();
        check_eq("wr_we_N3", {31'd0, vram_we}, 0);
        check_eq("wr_mem", {24'd0, mem[14'h3FFF]}, 32'hA5);

        // CPU read on idle bus
        tick();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 14'h0123;
        push_rd(1'b1, 8'h5A);
        tick(); cpu_req = 1'b0;
        check_eq("rd_re_N1", {31'd0, vram_re}, 0);
        tick();
        check_eq("rd_re_N2", {31'd0, vram_re}, 1);
        check_eq("rd_addr_N2", {18'd0, vram_addr}, 32'h0123);
        check_eq("rd_rv_N2", {31'd0, cpu_rvalid}, 0);
        tick();
        check_eq("rd_rv_N3", {30'd0, cpu_rvalid, ren_rvalid}, 32'd2);
        check_eq("rd_data_N3", {24'd0, cpu_rdata}, 32'h5A);
        repeat (2) tick();

        // Contention during display: CPU read waits MAX_WAIT cycles
        contend(1'b0, 14'h0123, 8'h00, 1'b1, 1'b0);

        // Blanking: CPU wins immediately, render next cycle
        display_active = 1'b0;
        tick();
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 14'h0040; cpu_wdata = 8'h33;
        tick();
        cpu_req = 1'b0; ren_req = 1'b1; ren_addr = 14'h0300;
        #1 check_eq("blank_gnt_N1", {31'd0, ren_gnt}, 0);
        tick();
        check_eq("blank_we_N2", {31'd0, vram_we}, 1);
        check_eq("blank_addr_N2", {18'd0, vram_addr}, 32'h0040);
        check_eq("blank_gnt_N2", {31'd0, ren_gnt}, 1);
        push_rd(1'b0, mem[14'h0300]);
        tick();
        ren_req = 1'b0;
        check_eq("blank_re_N3", {31'd0, vram_re}, 1);
        check_eq("blank_raddr_N3", {18'd0, vram_addr}, 32'h0300);
        repeat (3) tick();

        // Drop on busy: second request to 0x0010 is ignored
        wr_before = wr_cnt;
        contend(1'b1, 14'h0050, 8'h77, 1'b0, 1'b1);
        check_eq("drop_wr_count", wr_cnt - wr_before, 1);
        check_eq("drop_wr_addr", {18'd0, last_wr_addr}, 32'h0050);
        check_eq("drop_mem_50", {24'd0, mem[14'h0050]}, 32'h77);
        check_eq("drop_mem_10", {24'd0, mem[14'h0010]}, 32'(8'(16 ^ (16 >> 6))));

        // Reset while a render read is in flight
        display_active = 1'b1;
        tick();
        ren_req = 1'b1; ren_addr = 14'h0222;
        tick();
        ren_req = 1'b0;
        check_eq("mid_re", {31'd0, vram_re}, 1);
        reset = 1'b1;
        #1 check_eq("mid_rst_re", {30'd0, vram_re, vram_we}, 0);
        repeat (2) tick();
        check_eq("mid_rst_rv", {30'd0, cpu_rvalid, ren_rvalid}, 0);
        check_eq("mid_rst_addr", {18'd0, vram_addr}, 0);
        check_eq("mid_rst_wdata", {24'd0, vram_wdata}, 0);
        check_eq("mid_rst_busy", {31'd0, cpu_busy}, 0);
        reset = 1'b0;
        tick();

        // Service resumes after reset
        ren_req = 1'b1; ren_addr = 14'h0123;
        #1 check_eq("post_gnt", {31'd0, ren_gnt}, 1);
        push_rd(1'b0, 8'h5A);
        tick();
        ren_req = 1'b0;
        tick();
        check_eq("post_rv", {31'd0, ren_rvalid}, 1);
        check_eq("post_data", {24'd0, ren_rdata}, 32'h5A);
        repeat (3) tick();

        check_eq("sb_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
